// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: state encoding, default limits and operand width.
// Imported by the controller, its interface and the paired datapath.
package gcd_pkg;

  localparam int ITER_MAX_DEF = 15;
  localparam int CNT_W_DEF    = 4;
  localparam int DATA_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/gcd_controller_if.sv
// Control/flag bundle between the GCD controller (master) and its datapath/host side (slave).
// Signal names match the datapath pins one-for-one.
interface gcd_controller_if #(
  parameter int CNT_W = gcd_pkg::CNT_W_DEF
);

  logic             start;
  logic             notEqual;
  logic             lessThan;
  logic             x_sel;
  logic             y_sel;
  logic             x_write;
  logic             y_write;
  logic             d_write;
  logic             ready;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] iter_o;

  modport master (
    input  start, notEqual, lessThan,
    output x_sel, y_sel, x_write, y_write, d_write, ready, done, error, iter_o
  );

  modport slave (
    output start, notEqual, lessThan,
    input  x_sel, y_sel, x_write, y_write, d_write, ready, done, error, iter_o
  );

endinterface

// File: rtl/gcd_datapath.sv
// Subtractive GCD datapath: x/y working registers, result register d_o and the two compare flags.
// Driven entirely by the gcd_controller control pins.
module gcd_datapath
  import gcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic              x_sel,
  input  logic              y_sel,
  input  logic              x_write,
  input  logic              y_write,
  input  logic              d_write,
  output logic              notEqual,
  output logic              lessThan,
  output logic [DATA_W-1:0] d_o
);

  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_d <= '0;
    end else begin
      if (x_write) r_x <= x_sel ? (r_x - r_y) : x_i;
      if (y_write) r_y <= y_sel ? (r_y - r_x) : y_i;
      if (d_write) r_d <= r_x;
    end
  end

  assign notEqual = (r_x != r_y);
  assign lessThan = (r_x <  r_y);
  assign d_o      = r_d;

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD: loads operands, steers subtracts from the datapath flags,
// counts steps and aborts through ERR once ITER_MAX steps pass without convergence.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int ITER_MAX = ITER_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  gcd_controller_if.master bus
);

  state_t           r_state;
  logic [CNT_W-1:0] r_iter;
  logic             w_at_max;

  // >= rather than == so the counter can never step past the limit and wrap.
  assign w_at_max = (r_iter >= CNT_W'(ITER_MAX));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_LOAD;
            r_iter  <= '0;
          end
        end
        S_LOAD: r_state <= S_CALC;
        S_CALC: begin
          if (!bus.notEqual) begin
            r_state <= S_DONE;
          end else if (w_at_max) begin
            r_state <= S_ERR;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.x_sel   = 1'b0;
    bus.y_sel   = 1'b0;
    bus.x_write = 1'b0;
    bus.y_write = 1'b0;
    bus.d_write = 1'b0;
    bus.done    = 1'b0;
    bus.error   = 1'b0;
    // Gated by reset so a run abandoned mid-CALC cannot fire one last write.
    if (!reset) begin
      unique case (r_state)
        S_LOAD: begin
          bus.x_write = 1'b1;
          bus.y_write = 1'b1;
        end
        S_CALC: begin
          if (!bus.notEqual) begin
            bus.d_write = 1'b1;
          end else if (!w_at_max) begin
            if (bus.lessThan) begin
              bus.y_sel   = 1'b1;
              bus.y_write = 1'b1;
            end else begin
              bus.x_sel   = 1'b1;
              bus.x_write = 1'b1;
            end
          end
        end
        S_DONE: bus.done = 1'b1;
        S_ERR: begin
          bus.done  = 1'b1;
          bus.error = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (r_state == S_IDLE);
  assign bus.iter_o = r_iter;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench pairing gcd_controller with gcd_datapath; cycle numbers follow start-sampled = 0.
// Each comparison is an immediate assertion; a one-line summary ends the run.
module tb_gcd_controller;
  import gcd_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] x_i;
  logic [DATA_W-1:0] y_i;
  logic [DATA_W-1:0] d_o;

  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ywr_cnt  = 0;
  int base;

  gcd_controller_if #(.CNT_W(CNT_W_DEF)) bus ();

  gcd_controller #(.ITER_MAX(15), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  gcd_datapath dp (
    .clk      (clk),
    .reset    (reset),
    .x_i      (x_i),
    .y_i      (y_i),
    .x_sel    (bus.x_sel),
    .y_sel    (bus.y_sel),
    .x_write  (bus.x_write),
    .y_write  (bus.y_write),
    .d_write  (bus.d_write),
    .notEqual (bus.notEqual),
    .lessThan (bus.lessThan),
    .d_o      (d_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1)    done_cnt++;
    if (bus.y_write === 1'b1) ywr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents operands with start in cycle 0 and returns positioned in cycle 1.
  task automatic start_run(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] yv);
    x_i       = xv;
    y_i       = yv;
    bus.start = 1'b1;
    cyc       = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    while (bus.done !== 1'b1 && cyc < budget) tick();
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    x_i       = '0;
    y_i       = '0;
    tick();
    tick();
    check("rst_ready",   32'(bus.ready),   32'd1);
    check("rst_iter",    32'(bus.iter_o),  32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_error",   32'(bus.error),   32'd0);
    check("rst_x_write", 32'(bus.x_write), 32'd0);
    check("rst_d_write", 32'(bus.d_write), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready",  32'(bus.ready),   32'd1);

    // 6/4: two subtracts, done in cycle 5
    start_run(4'd6, 4'd4);
    check("c1_x_write", 32'(bus.x_write), 32'd1);
    check("c1_y_write", 32'(bus.y_write), 32'd1);
    check("c1_x_sel",   32'(bus.x_sel),   32'd0);
    check("c1_ready",   32'(bus.ready),   32'd0);
    tick();
    check("c2_x_sel",   32'(bus.x_sel),   32'd1);
    check("c2_x_write", 32'(bus.x_write), 32'd1);
    check("c2_y_write", 32'(bus.y_write), 32'd0);
    tick();
    check("c3_x",       32'(dp.r_x),      32'd2);
    check("c3_y_sel",   32'(bus.y_sel),   32'd1);
    check("c3_y_write", 32'(bus.y_write), 32'd1);
    tick();
    check("c4_y",       32'(dp.r_y),      32'd2);
    check("c4_d_write", 32'(bus.d_write), 32'd1);
    check("c4_x_write", 32'(bus.x_write), 32'd0);
    tick();
    check("c5_done",    32'(bus.done),    32'd1);
    check("c5_error",   32'(bus.error),   32'd0);
    check("c5_iter",    32'(bus.iter_o),  32'd2);
    tick();
    check("64_d_o",     32'(d_o),         32'd2);
    check("64_ready",   32'(bus.ready),   32'd1);
    check("64_done_off", 32'(bus.done),   32'd0);

    // 5/5: equal operands, no subtracts
    start_run(4'd5, 4'd5);
    tick();
    check("55_d_write_c2", 32'(bus.d_write), 32'd1);
    tick();
    check("55_done_c3",    32'(bus.done),    32'd1);
    check("55_iter",       32'(bus.iter_o),  32'd0);
    tick();
    check("55_d_o",        32'(d_o),         32'd5);

    // 15/1: fourteen x-subtracts
    start_run(4'd15, 4'd1);
    wait_done(40);
    check("151_done_cyc", 32'(cyc),        32'd17);
    check("151_error",    32'(bus.error),  32'd0);
    check("151_iter",     32'(bus.iter_o), 32'd14);
    tick();
    check("151_d_o",      32'(d_o),        32'd1);

    // 0/6: never converges, aborts after fifteen y-writes
    start_run(4'd0, 4'd6);
    tick();
    base = ywr_cnt;
    wait_done(40);
    check("06_done_cyc", 32'(cyc),            32'd18);
    check("06_error",    32'(bus.error),      32'd1);
    check("06_iter",     32'(bus.iter_o),     32'd15);
    check("06_y_writes", 32'(ywr_cnt - base), 32'd15);
    tick();
    check("06_d_o_kept", 32'(d_o),            32'd1);
    check("06_iter_hold", 32'(bus.iter_o),    32'd15);

    // reset in cycle 3 of a 6/4 run abandons it silently
    start_run(4'd6, 4'd4);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_y_write", 32'(bus.y_write), 32'd0);
    base = done_cnt;
    tick();
    check("mid_rst_ready", 32'(bus.ready),  32'd1);
    check("mid_rst_iter",  32'(bus.iter_o), 32'd0);
    check("mid_rst_done",  32'(bus.done),   32'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("mid_rst_no_done", 32'(done_cnt - base), 32'd0);
    start_run(4'd9, 4'd6);
    wait_done(20);
    check("96_done_cyc", 32'(cyc), 32'd5);
    tick();
    check("96_d_o",      32'(d_o), 32'd3);

    // start pulsed during CALC is ignored
    base = done_cnt;
    start_run(4'd12, 4'd8);
    tick();
    tick();
    bus.start = 1'b1;
    check("calc_ready", 32'(bus.ready), 32'd0);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("calc_one_done", 32'(done_cnt - base), 32'd1);
    check("calc_idle",     32'(bus.ready),       32'd1);
    check("128_d_o",       32'(d_o),             32'd4);

    // start held through DONE relaunches from IDLE
    start_run(4'd5, 4'd5);
    bus.start = 1'b1;
    tick();
    tick();
    check("hold_done_c3",   32'(bus.done),    32'd1);
    tick();
    check("hold_idle_c4",   32'(bus.ready),   32'd1);
    tick();
    check("hold_load_c5",   32'(bus.x_write), 32'd1);
    check("hold_busy_c5",   32'(bus.ready),   32'd0);
    bus.start = 1'b0;
    repeat (4) tick();
    check("hold_end_ready", 32'(bus.ready),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter ITER_MAX, default 15: maximum subtract steps before abort.
REQ-003 Parameter CNT_W, default 4: width of the iteration counter, sized to hold ITER_MAX.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  request a new GCD run; accepted only when ready=1.
REQ-007 notEqual  in  1  datapath flag, x register != y register (combinational from registers).
REQ-008 lessThan  in  1  datapath flag, x register < y register.
REQ-009 x_sel  out  1  0 = datapath loads x_i into x; 1 = datapath loads x-y into x.
REQ-010 y_sel  out  1  0 = datapath loads y_i into y; 1 = datapath loads y-x into y.
REQ-011 x_write, y_write  out  1 each  write enables for the x and y registers.
REQ-012 d_write  out  1  write enable for the result register d_o (loads x).
REQ-013 ready  out  1  high in IDLE only.
REQ-014 done  out  1  one-cycle pulse at the end of every run.
REQ-015 error  out  1  one-cycle pulse coincident with done when the run aborted.
REQ-016 iter_o  out  CNT_W  subtract steps taken in the current or last run.

Function
REQ-017 States SHALL be IDLE, LOAD, CALC, DONE and ERR.
REQ-018 Control outputs SHALL be decoded from state and flags; no flag-to-output register stage.
REQ-019 IDLE: ready=1 and all write enables 0; start=1 SHALL move to LOAD next cycle and clear iter_o.
REQ-020 LOAD, one cycle: x_sel=0, y_sel=0, x_write=1, y_write=1; then go to CALC.
REQ-021 CALC with notEqual=0: d_write=1 and no other write; go to DONE.
REQ-022 CALC with notEqual=1, lessThan=1, and iter_o<ITER_MAX: y_sel=1, y_write=1, iter_o+1; stay in CALC.
REQ-023 CALC with notEqual=1, lessThan=0, and iter_o<ITER_MAX: x_sel=1, x_write=1, iter_o+1; stay in CALC.
REQ-024 CALC with notEqual=1 and iter_o==ITER_MAX: no write, d_o unchanged; go to ERR.
REQ-025 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-026 ERR SHALL assert done=1 and error=1 for one cycle, then go to IDLE.
REQ-027 Latency: start is sampled in cycle 0, LOAD is cycle 1, the first CALC is cycle 2, and done occurs in cycle 3+N for N subtract steps.
REQ-028 start while ready=0 SHALL be ignored and not queued; start held high through DONE SHALL begin a new run from IDLE.
REQ-029 x_sel/y_sel SHALL be 0 in every state and case not named above.
REQ-030 iter_o SHALL saturate at ITER_MAX and never wrap; it holds its value in IDLE until the next accepted start.
REQ-031 A zero operand with the other operand nonzero never converges; the run SHALL end through ERR after ITER_MAX steps.

Reset
REQ-032 reset=1 SHALL force IDLE on the next edge from any state, including mid-CALC, and abandon the run with no done pulse.
REQ-033 Values while in reset: ready=1 after the edge, iter_o=0, and done, error, x_sel, y_sel, x_write, y_write, d_write all 0.

Structure
REQ-034 Package gcd_pkg SHALL hold the state encoding enum, ITER_MAX default, CNT_W default and operand width (4).
REQ-035 The block SHALL be a single module with no sub-modules; the iteration counter is inline.
REQ-036 The block SHALL connect port-for-port to the existing Datapath flag and control pins.

Verification
REQ-037 Bench SHALL pair gcd_controller with Datapath and cover:
- x_i=6, y_i=4, start pulse -> x=2 at cycle 3, y=2 at cycle 4, d_write in cycle 4, done in cycle 5, d_o=2, iter_o=2, error=0.
- x_i=5, y_i=5 -> d_write in cycle 2, done in cycle 3, d_o=5, iter_o=0.
- x_i=15, y_i=1 -> 14 x-subtracts, d_o=1, iter_o=14, done in cycle 17, error=0.
- x_i=0, y_i=6 -> 15 y-writes, then done=1 with error=1, d_o unchanged, iter_o=15.
- reset asserted in cycle 3 of the 6/4 run -> IDLE, ready=1, no done pulse; a following 9/6 run gives d_o=3.
- start pulsed again during CALC -> ignored; exactly one done pulse.
